// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit-serial shift on device clocks,
// odd parity, stop bit and ACK capture. Lines are open-drain; the *_oe outputs only ever pull low.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 3000,
  parameter int START_TIMEOUT_CYCLES = 375000,
  parameter int BIT_TIMEOUT_CYCLES   = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int TMAX_A = (START_TIMEOUT_CYCLES > INHIBIT_CYCLES) ? START_TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TMAX   = (TMAX_A > BIT_TIMEOUT_CYCLES) ? TMAX_A : BIT_TIMEOUT_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_FIRST, SHIFT, WAIT_IDLE, DONE, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_reg_q, ack_reg_d;
  logic          ack_ok_q, ack_ok_d;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fe;

  // Synchronizers reset to the idle-high bus level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fe = clk_prev & ~clk_s2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_reg_q <= 1'b0;
      ack_ok_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_reg_q <= ack_reg_d;
      ack_ok_q  <= ack_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_reg_d = ack_reg_q;
    ack_ok_d  = ack_ok_q;

    unique case (state_q)
      IDLE: begin
        timer_d   = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d  = {1'b1, ~^tx_data, tx_data};
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (timer_q == INH_LAST) begin
          data_oe_d = 1'b1;
          timer_d   = '0;
          state_d   = RTS;
        end
      end
      RTS: begin
        // Start bit has been on the wire for a cycle; now hand the clock to the device.
        clk_oe_d = 1'b0;
        timer_d  = '0;
        cnt_d    = '0;
        state_d  = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (fe) begin
          data_oe_d = ~frame_q[0];
          cnt_d     = 4'd1;
          timer_d   = '0;
          state_d   = SHIFT;
        end else if (timer_q == START_LAST) begin
          state_d = ERR;
        end
      end
      SHIFT: begin
        if (fe) begin
          cnt_d   = cnt_q + 4'd1;
          timer_d = '0;
          if (cnt_q == 4'd10) begin
            ack_reg_d = ~data_s2;
            data_oe_d = 1'b0;
            state_d   = WAIT_IDLE;
          end else begin
            // Edge n presents frame bit n-1; edge 10 presents the stop bit (release).
            data_oe_d = ~frame_q[cnt_q];
          end
        end else if (timer_q == BIT_LAST) begin
          state_d = ERR;
        end
      end
      WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          ack_ok_d = ack_reg_q;
          state_d  = DONE;
        end else if (timer_q == BIT_LAST) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == ERR) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q inside {INHIBIT, RTS, WAIT_FIRST, SHIFT, WAIT_IDLE});
  assign done        = (state_q == DONE);
  assign err         = (state_q == ERR);
  assign ack_ok      = ack_ok_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a wired-AND PS/2 device model clocks frames out of the host and a
// byte-level reference computes the expected 10-bit frame (data LSB first, odd parity, stop).
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 10;
  localparam int STO  = 100;
  localparam int BTO  = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_ok, err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT_CYCLES(STO),
    .BIT_TIMEOUT_CYCLES(BTO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .ack_ok(ack_ok), .err(err),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  int compares = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  time t_release, t_fall_last, t_end;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame straight from the protocol: count ones, pick parity to make the total odd.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0), d};
  endfunction

  task automatic device(input int edges, input bit ack,
                        output logic [9:0] bits, output int inh_len, output bit start_ok);
    int t = 0;
    bits = '0;
    inh_len = 0;
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    while (ps2_clk_oe && t < 1000) begin inh_len++; @(negedge clk); t++; end
    t_release = $time;
    start_ok = !ps2_clk_oe && ps2_data_oe;
    repeat (5) @(negedge clk);
    for (int i = 1; i <= edges; i++) begin
      if (i == 11) dev_data_low = ack;
      dev_clk_low = 1'b1;
      t_fall_last = $time;
      repeat (HALF) @(negedge clk);
      if (i <= 10) bits[i-1] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic start_txn(input logic [7:0] d, input bit hold, input logic [7:0] alt);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (hold) tx_data = alt;
    else      tx_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] d, input bit ack, input int edges,
                         input bit hold, input logic [7:0] alt,
                         output logic [9:0] bits, output int inh_len, output bit start_ok,
                         output bit got_done, output bit got_err, output bit got_ack,
                         output bit oe_at_end);
    start_txn(d, hold, alt);
    got_done = 0; got_err = 0; got_ack = 0; oe_at_end = 1;
    fork
      device(edges, ack, bits, inh_len, start_ok);
      begin
        int t = 0;
        while (!(done || err) && t < 3000) begin @(negedge clk); t++; end
        got_done  = done;
        got_err   = err;
        got_ack   = ack_ok;
        oe_at_end = ps2_clk_oe | ps2_data_oe;
        t_end     = $time;
        tx_valid  = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         edges;
    bit         exp_done;
    bit         exp_err;
    bit         exp_ack;
    int         exp_par;   // -1: parity not spot-checked
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [9:0] bits;
    int inh_len;
    bit start_ok, got_done, got_err, got_ack, oe_end;
    int d0, e0, busy_seen;

    vecs[0] = '{8'hED, 1'b1, 11, 1'b1, 1'b0, 1'b1, 1};
    vecs[1] = '{8'h01, 1'b1, 11, 1'b1, 1'b0, 1'b1, 0};
    vecs[2] = '{8'h00, 1'b1, 11, 1'b1, 1'b0, 1'b1, 1};
    vecs[3] = '{8'hFF, 1'b0, 11, 1'b1, 1'b0, 1'b0, 1};
    vecs[4] = '{8'hF4, 1'b1, 11, 1'b1, 1'b0, 1'b1, -1};
    vecs[5] = '{8'hAA, 1'b1, 5,  1'b0, 1'b1, 1'b0, -1};

    repeat (4) @(negedge clk);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_ack_ok", ack_ok, 0);
    chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_tx_ready", tx_ready, 1);

    foreach (vecs[k]) begin
      run_txn(vecs[k].data, vecs[k].ack, vecs[k].edges, 1'b0, 8'h00,
              bits, inh_len, start_ok, got_done, got_err, got_ack, oe_end);
      chk($sformatf("v%0d_inhibit_len_ge", k), (inh_len >= INH), 1);
      chk($sformatf("v%0d_start_bit", k), start_ok, 1);
      chk($sformatf("v%0d_done", k), got_done, vecs[k].exp_done);
      chk($sformatf("v%0d_err", k), got_err, vecs[k].exp_err);
      if (vecs[k].exp_done) chk($sformatf("v%0d_ack_ok", k), got_ack, vecs[k].exp_ack);
      if (vecs[k].edges == 11) chk($sformatf("v%0d_frame", k), bits, model_frame(vecs[k].data));
      if (vecs[k].exp_par >= 0) chk($sformatf("v%0d_parity", k), bits[8], vecs[k].exp_par);
      if (vecs[k].exp_err) begin
        chk($sformatf("v%0d_bit_timeout_window", k),
            ((t_end - t_fall_last) / 10 >= BTO) && ((t_end - t_fall_last) / 10 <= BTO + 5), 1);
        chk($sformatf("v%0d_err_lines", k), oe_end, 0);
      end
      chk($sformatf("v%0d_post_ready", k), tx_ready, 1);
      chk($sformatf("v%0d_post_busy", k), busy, 0);
      chk($sformatf("v%0d_post_oe", k), {ps2_clk_oe, ps2_data_oe}, 0);
    end

    // Device never clocks: err exactly STO cycles after clock release, no done.
    d0 = done_cnt;
    run_txn(8'hF4, 1'b1, 0, 1'b0, 8'h00, bits, inh_len, start_ok, got_done, got_err, got_ack, oe_end);
    chk("start_to_err", got_err, 1);
    chk("start_to_cycles", (t_end - t_release) / 10, STO);
    chk("start_to_lines", oe_end, 0);
    chk("start_to_no_done", done_cnt - d0, 0);
    chk("start_to_ready", tx_ready, 1);

    // Random bytes and ACK against the reference frame.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] rd;
      bit ra;
      rd = 8'($urandom);
      ra = 1'($urandom_range(0, 1));
      run_txn(rd, ra, 11, 1'b0, 8'h00, bits, inh_len, start_ok, got_done, got_err, got_ack, oe_end);
      chk($sformatf("rnd%0d_frame_%02h", r, rd), bits, model_frame(rd));
      chk($sformatf("rnd%0d_done", r), got_done, 1);
      chk($sformatf("rnd%0d_ack", r), got_ack, ra);
    end

    // tx_valid held with a different byte while busy: only the first byte goes out.
    run_txn(8'hED, 1'b1, 11, 1'b1, 8'h12, bits, inh_len, start_ok, got_done, got_err, got_ack, oe_end);
    chk("hold_frame", bits, model_frame(8'hED));
    chk("hold_done", got_done, 1);
    busy_seen = 0;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (busy) busy_seen++; end
    chk("hold_no_second", busy_seen, 0);

    // Reset in the middle of a frame.
    start_txn(8'hF4, 1'b0, 8'h00);
    device(4, 1'b0, bits, inh_len, start_ok);
    chk("mid_busy_before_reset", busy, 1);
    d0 = done_cnt;
    e0 = err_cnt;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("mid_reset_ready", tx_ready, 1);
    reset_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("mid_reset_no_done", done_cnt - d0, 0);
    chk("mid_reset_no_err", err_cnt - e0, 0);
    chk("mid_reset_idle", tx_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
